// File: rtl/event_buffer_if.sv
// Event handshake bundle: filter-side strobe and readout-side valid/ready.
// master drives events in and accepts them out; slave is the buffer.
interface event_buffer_if;
    logic       in_valid;
    logic [1:0] in_x;
    logic [1:0] in_y;
    logic [1:0] in_p;
    logic [1:0] in_t;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid, in_x, in_y, in_p, in_t, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_x, in_y, in_p, in_t, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/event_buffer.sv
// Event FIFO with drop counting, fill level and sticky overflow.
// Optional EVENT_BUF_DEDUP_EN discards repeats of the last accepted word.
module event_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    event_buffer_if.slave              ev,
    input  logic                       drop_clr,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;

    logic [7:0] in_word;
    logic       full;
    logic       pop;
    logic       cand;
    logic       push;
    logic       drop;

    assign in_word = {ev.in_x, ev.in_y, ev.in_p, ev.in_t};
    assign full    = (level_q == LW'(DEPTH));
    assign pop     = ev.out_valid && ev.out_ready;

`ifdef EVENT_BUF_DEDUP_EN
    logic [7:0] last_word_q, last_word_d;
    logic       last_vld_q, last_vld_d;

    // Held filter outputs repeat the previous word; those are not new events
    assign cand = ev.in_valid && !(last_vld_q && (in_word == last_word_q));

    always_comb begin
        last_word_d = last_word_q;
        last_vld_d  = last_vld_q;
        if (push) begin
            last_word_d = in_word;
            last_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_vld_q <= 1'b0;
        end else begin
            last_vld_q <= last_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        last_word_q <= last_word_d;
    end
`else
    assign cand = ev.in_valid;
`endif

    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        if (push) begin
            mem_d[wptr_q] = in_word;
            wptr_d        = wptr_q + AW'(1);
        end
    end

    always_comb begin
        rptr_d = rptr_q;
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // A drop in the clearing cycle still counts, so it lands as 1
    always_comb begin
        drop_cnt_d = drop_clr ? '0 : drop_cnt_q;
        overflow_d = drop_clr ? 1'b0 : overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_clr) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ev.out_valid = (level_q != '0);
    assign ev.out_data  = mem_q[rptr_q];
    assign level        = level_q;
    assign drop_cnt     = drop_cnt_q;
    assign overflow     = overflow_q;
endmodule
